// File: rtl/rr_grant_sched.sv
// Round-robin grant sequencer: drives the encoder pointer, captures its one-hot grant, and presents the binary index downstream.
// Latency: one cycle from grant sample to out_valid. After acceptance, req_clr pulses for one cycle and then one settle cycle follows.
// Backpressure: the index is held while out_ready is low. No new grant is sampled until the handshake completes.
module rr_grant_sched #(
    parameter int WIDTH = 1024,
    parameter int LOG_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ptr_load,
    input  logic [LOG_W-1:0] ptr_val,
    input  logic [WIDTH-1:0] gnt_in,
    input  logic             gnt_vld,
    output logic [LOG_W-1:0] p_enc,
    output logic             out_valid,
    output logic [LOG_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [WIDTH-1:0] req_clr,
    output logic             err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [LOG_W-1:0] ONE_L = LOG_W'(1);

    logic [1:0]       state_q, state_d;
    logic [LOG_W-1:0] p_enc_q, p_enc_d;
    logic [LOG_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] req_clr_q, req_clr_d;
    logic             err_q, err_d;

    logic             gnt_onehot;
    logic [LOG_W-1:0] gnt_idx;

    // OR-encoding is exact only for one-hot input; gnt_idx is consumed only when gnt_onehot is set.
    always_comb begin
        gnt_onehot = (gnt_in != '0) && ((gnt_in & (gnt_in - ONE_W)) == '0);
        gnt_idx    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (gnt_in[i]) begin
                gnt_idx = gnt_idx | LOG_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        p_enc_d     = p_enc_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        req_clr_d   = '0;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld && !gnt_onehot) begin
                    err_d = 1'b1;
                end else if (en && gnt_vld) begin
                    out_idx_d   = gnt_idx;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    req_clr_d   = ONE_W << out_idx_q;
                    // WIDTH is a power of two, so this naturally wraps to 0.
                    p_enc_d     = out_idx_q + ONE_L;
                    state_d     = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = ST_IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // A software load overrides the post-accept pointer advance.
        if (ptr_load) begin
            p_enc_d = ptr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            p_enc_q     <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            req_clr_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_enc_q     <= p_enc_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            req_clr_q   <= req_clr_d;
            err_q       <= err_d;
        end
    end

    assign p_enc     = p_enc_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign req_clr   = req_clr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched at WIDTH=8. A behavioural encoder is fed from a request model that req_clr clears.
module tb_rr_grant_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ptr_load;
    logic [2:0] ptr_val;
    logic [7:0] gnt_in;
    logic       gnt_vld;
    logic [2:0] p_enc;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_ready;
    logic [7:0] req_clr;
    logic       err;

    logic [7:0] req;
    logic [7:0] enc_gnt;
    logic       force_en;
    logic [2:0] jj;
    logic       found;

    int n_vec;
    int n_err;

    rr_grant_sched #(.WIDTH(8), .LOG_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ptr_load  (ptr_load),
        .ptr_val   (ptr_val),
        .gnt_in    (gnt_in),
        .gnt_vld   (gnt_vld),
        .p_enc     (p_enc),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .req_clr   (req_clr),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder model: first request at or above p_enc, wrapping to the lowest index.
    always_comb begin
        enc_gnt = '0;
        found   = 1'b0;
        jj      = '0;
        for (int k = 0; k < 8; k++) begin
            jj = p_enc + 3'(k);
            if (!found && req[jj]) begin
                enc_gnt[jj] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign gnt_in  = force_en ? 8'h0C : enc_gnt;
    assign gnt_vld = force_en ? 1'b1 : (req != 8'h00);

    // One clock. The request model absorbs the req_clr pulse seen in the cycle just ended.
    task automatic tick();
        logic [7:0] c;
        c = req_clr;
        @(posedge clk);
        #1;
        req = req & ~c;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec += 5;
        if (p_enc !== 3'd0) begin n_err++; $display("FAIL reset_p_enc got %0d want 0", p_enc); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_idx !== 3'd0) begin n_err++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
        if (req_clr !== 8'h00) begin n_err++; $display("FAIL reset_req_clr got %h want 00", req_clr); end
        if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_idx [3];
        logic [2:0] exp_ptr [3];
        logic [7:0] exp_clr [3];
        bit ok;
        exp_idx = '{3'd2, 3'd5, 3'd7};
        exp_ptr = '{3'd3, 3'd6, 3'd0};
        exp_clr = '{8'h04, 8'h20, 8'h80};
        req = 8'b1010_0100;
        out_ready = 1'b1;
        en = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_valid(ok);
            n_vec += 2;
            if (!ok) begin n_err++; $display("FAIL rr_valid[%0d] got %b want 1", g, out_valid); end
            if (out_idx !== exp_idx[g]) begin n_err++; $display("FAIL rr_idx[%0d] got %0d want %0d", g, out_idx, exp_idx[g]); end
            tick();
            n_vec += 3;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_drop[%0d] got %b want 0", g, out_valid); end
            if (req_clr !== exp_clr[g]) begin n_err++; $display("FAIL rr_clr[%0d] got %h want %h", g, req_clr, exp_clr[g]); end
            if (p_enc !== exp_ptr[g]) begin n_err++; $display("FAIL rr_ptr[%0d] got %0d want %0d", g, p_enc, exp_ptr[g]); end
            tick();
            n_vec++;
            if (req_clr !== 8'h00) begin n_err++; $display("FAIL rr_clr_pulse[%0d] got %h want 00", g, req_clr); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        tick();
        tick();
        req = 8'b1000_0001;
        en = 1'b0;
        ptr_load = 1'b1;
        ptr_val = 3'd7;
        tick();
        ptr_load = 1'b0;
        n_vec++;
        if (p_enc !== 3'd7) begin n_err++; $display("FAIL wrap_load got %0d want 7", p_enc); end
        en = 1'b1;
        wait_valid(ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL wrap_valid0 got %b want 1", out_valid); end
        if (out_idx !== 3'd7) begin n_err++; $display("FAIL wrap_idx0 got %0d want 7", out_idx); end
        tick();
        n_vec += 2;
        if (p_enc !== 3'd0) begin n_err++; $display("FAIL wrap_ptr0 got %0d want 0", p_enc); end
        if (req_clr !== 8'h80) begin n_err++; $display("FAIL wrap_clr0 got %h want 80", req_clr); end
        wait_valid(ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL wrap_valid1 got %b want 1", out_valid); end
        if (out_idx !== 3'd0) begin n_err++; $display("FAIL wrap_idx1 got %0d want 0", out_idx); end
        tick();
        n_vec += 2;
        if (p_enc !== 3'd1) begin n_err++; $display("FAIL wrap_ptr1 got %0d want 1", p_enc); end
        if (req_clr !== 8'h01) begin n_err++; $display("FAIL wrap_clr1 got %h want 01", req_clr); end
        tick();
        tick();
    endtask

    task automatic test_hold();
        bit ok;
        out_ready = 1'b0;
        req = 8'h08;
        wait_valid(ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL hold_valid got %b want 1", out_valid); end
        if (out_idx !== 3'd3) begin n_err++; $display("FAIL hold_idx got %0d want 3", out_idx); end
        for (int i = 0; i < 10; i++) begin
            req = 8'h08 | 8'(i * 37);
            tick();
            n_vec += 3;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_stall_valid[%0d] got %b want 1", i, out_valid); end
            if (out_idx !== 3'd3) begin n_err++; $display("FAIL hold_stall_idx[%0d] got %0d want 3", i, out_idx); end
            if (req_clr !== 8'h00) begin n_err++; $display("FAIL hold_stall_clr[%0d] got %h want 00", i, req_clr); end
        end
        out_ready = 1'b1;
        tick();
        req = 8'h00;
        out_ready = 1'b0;
        n_vec += 3;
        if (req_clr !== 8'h08) begin n_err++; $display("FAIL hold_clr got %h want 08", req_clr); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_drop got %b want 0", out_valid); end
        if (p_enc !== 3'd4) begin n_err++; $display("FAIL hold_ptr got %0d want 4", p_enc); end
        tick();
        n_vec++;
        if (req_clr !== 8'h00) begin n_err++; $display("FAIL hold_clr_pulse got %h want 00", req_clr); end
    endtask

    task automatic test_ptr_on_accept();
        bit ok;
        req = 8'h10;
        wait_valid(ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL pa_valid got %b want 1", out_valid); end
        if (out_idx !== 3'd4) begin n_err++; $display("FAIL pa_idx got %0d want 4", out_idx); end
        out_ready = 1'b1;
        ptr_load = 1'b1;
        ptr_val = 3'd1;
        tick();
        ptr_load = 1'b0;
        out_ready = 1'b0;
        n_vec += 3;
        if (p_enc !== 3'd1) begin n_err++; $display("FAIL pa_ptr got %0d want 1", p_enc); end
        if (req_clr !== 8'h10) begin n_err++; $display("FAIL pa_clr got %h want 10", req_clr); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL pa_drop got %b want 0", out_valid); end
        tick();
        n_vec++;
        if (req_clr !== 8'h00) begin n_err++; $display("FAIL pa_clr_pulse got %h want 00", req_clr); end
    endtask

    task automatic test_err();
        force_en = 1'b1;
        tick();
        force_en = 1'b0;
        n_vec += 2;
        if (err !== 1'b1) begin n_err++; $display("FAIL err_set got %b want 1", err); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL err_no_capture got %b want 0", out_valid); end
        tick();
        tick();
        tick();
        n_vec += 2;
        if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", err); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL err_idle got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        out_ready = 1'b0;
        req = 8'h40;
        wait_valid(ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL rmh_valid got %b want 1", out_valid); end
        if (out_idx !== 3'd6) begin n_err++; $display("FAIL rmh_idx got %0d want 6", out_idx); end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec += 4;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmh_async_valid got %b want 0", out_valid); end
        if (req_clr !== 8'h00) begin n_err++; $display("FAIL rmh_async_clr got %h want 00", req_clr); end
        if (p_enc !== 3'd0) begin n_err++; $display("FAIL rmh_async_ptr got %0d want 0", p_enc); end
        if (err !== 1'b0) begin n_err++; $display("FAIL rmh_async_err got %b want 0", err); end
        tick();
        rst_n = 1'b1;
        n_vec++;
        if (req !== 8'h40) begin n_err++; $display("FAIL rmh_req_kept got %h want 40", req); end
        wait_valid(ok);
        n_vec += 3;
        if (!ok) begin n_err++; $display("FAIL rmh_regrant_valid got %b want 1", out_valid); end
        if (out_idx !== 3'd6) begin n_err++; $display("FAIL rmh_regrant_idx got %0d want 6", out_idx); end
        if (p_enc !== 3'd0) begin n_err++; $display("FAIL rmh_regrant_ptr got %0d want 0", p_enc); end
        out_ready = 1'b1;
        tick();
        n_vec += 2;
        if (req_clr !== 8'h40) begin n_err++; $display("FAIL rmh_clr got %h want 40", req_clr); end
        if (p_enc !== 3'd7) begin n_err++; $display("FAIL rmh_ptr got %0d want 7", p_enc); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en = 1'b0;
        ptr_load = 1'b0;
        ptr_val = 3'd0;
        out_ready = 1'b0;
        req = 8'h00;
        force_en = 1'b0;

        test_reset();
        test_round_robin();
        test_wrap();
        test_hold();
        test_ptr_on_accept();
        test_err();
        test_reset_mid_hold();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
